// File: rtl/sm4_key_schedule_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sm4_key_schedule_pkg
//  Brief    : SM4 key-schedule constants (FK, CK generator, S-box) and the
//             state encoding shared by the key-schedule block.
//  Revision : 1.0  initial release
// ============================================================================
package sm4_key_schedule_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_e;

  // System parameter FK0..FK3, FK0 in the top word
  localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // SM4 S-box, shared with the round datapath
  localparam logic [7:0] SBOX [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
  };

  // CK_i: byte j of word i is (4*i + j) * 7 mod 256, byte 0 in the top lane
  function automatic logic [31:0] ck_word(input logic [4:0] idx);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[31-8*j -: 8] = 8'((int'(idx) * 4 + j) * 7);
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sm4_key_schedule_if.sv
`default_nettype none
// ============================================================================
//  Module   : sm4_key_schedule_if
//  Brief    : Key-load and round-key read bus between the key schedule
//             (slave) and the key loader / round datapath (master).
//  Revision : 1.0  initial release
// ============================================================================
interface sm4_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid_in;
  logic         key_ready_out;
  logic         keys_ready_out;
  logic [4:0]   round_index_in;
  logic         decrypt_in;
  logic [31:0]  round_key_out;

  modport master (
    output key_in, key_valid_in, round_index_in, decrypt_in,
    input  key_ready_out, keys_ready_out, round_key_out
  );

  modport slave (
    input  key_in, key_valid_in, round_index_in, decrypt_in,
    output key_ready_out, keys_ready_out, round_key_out
  );
endinterface
`default_nettype wire

// File: rtl/sm4_key_schedule_round.sv
`default_nettype none
// ============================================================================
//  Module   : one_round_for_key_expansion
//  Brief    : One combinational key-expansion step: rk = K0 ^ T'(K1^K2^K3^CK)
//             and the shifted state {K1, K2, K3, rk}.
//  Revision : 1.0  initial release
// ============================================================================
module one_round_for_key_expansion
  import sm4_key_schedule_pkg::*;
(
  input  wire logic [127:0] k_i,
  input  wire logic [31:0]  ck_i,
  output logic      [127:0] k_o
);
  logic [31:0] b_d;
  logic [31:0] tau_d;
  logic [31:0] lp_d;

  assign b_d = k_i[95:64] ^ k_i[63:32] ^ k_i[31:0] ^ ck_i;

  // Non-linear layer: four S-boxes in parallel
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    assign tau_d[8*g +: 8] = SBOX[b_d[8*g +: 8]];
  end

  // Key-schedule linear layer L'(B) = B ^ (B<<<13) ^ (B<<<23)
  assign lp_d = tau_d ^ {tau_d[18:0], tau_d[31:19]} ^ {tau_d[8:0], tau_d[31:9]};

  assign k_o = {k_i[95:0], k_i[127:96] ^ lp_d};
endmodule
`default_nettype wire

// File: rtl/sm4_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : sm4_key_schedule
//  Brief    : Expands a 128-bit SM4 master key into 32 round keys over 32
//             cycles and serves them with one-cycle read latency, forward
//             order for encryption and reverse order for decryption.
//  Revision : 1.0  initial release
// ============================================================================
module sm4_key_schedule
  import sm4_key_schedule_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  sm4_key_schedule_if.slave bus
);
  state_e       state_q;
  logic [4:0]   cnt_q;
  logic [127:0] k_q;
  logic [127:0] k_d;
  logic         keys_ready_q;
  logic [31:0]  round_key_q;
  logic [31:0]  store_q [32];
  logic [4:0]   addr_d;

  assign bus.key_ready_out  = (state_q != ST_EXPAND);
  assign bus.keys_ready_out = keys_ready_q;
  assign bus.round_key_out  = round_key_q;

  one_round_for_key_expansion u_round (
    .k_i  (k_q),
    .ck_i (ck_word(cnt_q)),
    .k_o  (k_d)
  );

  // Control FSM: accepts a key outside EXPAND, then steps K once per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      k_q          <= '0;
      keys_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY: begin
          if (bus.key_valid_in) begin
            state_q      <= ST_EXPAND;
            k_q          <= bus.key_in ^ FK;
            cnt_q        <= 5'd0;
            keys_ready_q <= 1'b0;
          end
        end
        ST_EXPAND: begin
          k_q   <= k_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q      <= ST_READY;
            keys_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Round-key store: written only while expanding, otherwise holds
  always_ff @(posedge clk) begin
    if (state_q == ST_EXPAND) begin
      store_q[cnt_q] <= k_d[31:0];
    end
  end

  // Decryption walks the store backwards; 5-bit wrap makes 31-idx exact
  assign addr_d = bus.decrypt_in ? (5'd31 - bus.round_index_in) : bus.round_index_in;

  // Registered read port, zero until a complete key set is present
  always_ff @(posedge clk) begin
    if (reset) begin
      round_key_q <= 32'h0;
    end else begin
      round_key_q <= keys_ready_q ? store_q[addr_d] : 32'h0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sm4_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm4_key_schedule
//  Brief    : Self-checking bench for sm4_key_schedule with a behavioural
//             key-schedule reference and a read scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm4_key_schedule;

  localparam logic [127:0] STD_MK   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] OTHER_MK = 128'h00112233445566778899aabbccddeeff;

  localparam logic [2047:0] SBOX_TB = {
    256'hd690e9fecce13db716b614c228fb2c052b679a762abe04c3aa44132649860699,
    256'h9c4250f491ef987a33540b43edcfac62e4b31ca9c908e89580df94fa758f3fa6,
    256'h4707a7fcf37317ba83593c19e6854fa8686b81b27164da8bf8eb0f4b70569d35,
    256'h1e240e5e6358d1a225227c3b01217887d40046579fd327524c3602e7a0c4c89e,
    256'heabf8ad240c738b5a3f7f2cef96115a1e0ae5da49b341a55ad933230f58cb1e3,
    256'h1df6e22e8266ca60c02923ab0d534e6fd5db3745defd8e2f03ff6a726d6c5b51,
    256'h8d1baf92bbddbc7f11d95c411f105ad80ac13188a5cd7bbd2d74d012b8e5b4b0,
    256'h8969974a0c96777e65b9f109c56ec68418f07dec3adc4d2079ee5f3ed7cb3948
  };

  logic        clk = 1'b0;
  logic        reset;
  int          checks = 0;
  int          passed = 0;
  logic [31:0] gold [32];
  logic [31:0] exp_q [$];

  sm4_key_schedule_if bus ();

  sm4_key_schedule dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] tb_tprime(input logic [31:0] b);
    logic [2047:0] tab;
    logic [31:0]   s;
    logic [7:0]    x;
    tab = SBOX_TB;
    for (int j = 0; j < 4; j++) begin
      x = b[8*j +: 8];
      s[8*j +: 8] = tab[2047 - 8*int'(x) -: 8];
    end
    return s ^ ((s << 13) | (s >> 19)) ^ ((s << 23) | (s >> 9));
  endfunction

  task automatic model_expand(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] fk [4];
    logic [31:0] ck;
    logic [31:0] nk;
    fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      nk = k[0] ^ tb_tprime(k[1] ^ k[2] ^ k[3] ^ ck);
      gold[i] = nk;
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = nk;
    end
  endtask

  task automatic load_key(input logic [127:0] mk);
    bus.key_in       = mk;
    bus.key_valid_in = 1'b1;
    tick();
    bus.key_valid_in = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.keys_ready_out !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (bus.key_ready_out !== 1'b1) $display("FAIL reset_key_ready got %b want 1", bus.key_ready_out);
    else passed++;
    checks++;
    if (bus.keys_ready_out !== 1'b0) $display("FAIL reset_keys_ready got %b want 0", bus.keys_ready_out);
    else passed++;
    checks++;
    if (bus.round_key_out !== 32'h0) $display("FAIL reset_round_key got %h want 0", bus.round_key_out);
    else passed++;
  endtask

  task automatic test_standard_vector;
    int cycles;
    logic [31:0] want [3];
    logic [4:0]  idx [3];
    logic [31:0] exp;
    want = '{32'hf12186f9, 32'h41662b61, 32'h9124a012};
    idx  = '{5'd0, 5'd1, 5'd31};
    load_key(STD_MK);
    checks++;
    if (bus.key_ready_out !== 1'b0) $display("FAIL std_busy key_ready got %b want 0", bus.key_ready_out);
    else passed++;
    wait_ready(cycles);
    checks++;
    if (cycles != 32) $display("FAIL std_latency got %0d cycles want 32", cycles);
    else passed++;
    checks++;
    if (bus.key_ready_out !== 1'b1) $display("FAIL std_ready key_ready got %b want 1", bus.key_ready_out);
    else passed++;
    bus.decrypt_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.round_index_in = idx[i];
      exp_q.push_back(want[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL std_rk%0d got %h want %h", idx[i], bus.round_key_out, exp);
      else passed++;
    end
  endtask

  task automatic test_decrypt_order;
    logic [31:0] want [2];
    logic [4:0]  idx [2];
    logic [31:0] exp;
    want = '{32'h9124a012, 32'hf12186f9};
    idx  = '{5'd0, 5'd31};
    bus.decrypt_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.round_index_in = idx[i];
      exp_q.push_back(want[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL dec_idx%0d got %h want %h", idx[i], bus.round_key_out, exp);
      else passed++;
    end
    bus.decrypt_in = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    model_expand(STD_MK);
    bus.decrypt_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      bus.round_index_in = 5'(i);
      exp_q.push_back(gold[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL b2b_rk%0d got %h want %h", i, bus.round_key_out, exp);
      else passed++;
    end
  endtask

  task automatic test_ignore_during_expand;
    int cycles;
    logic [31:0] exp;
    model_expand(STD_MK);
    load_key(STD_MK);
    for (int i = 0; i < 10; i++) tick();
    bus.key_in       = OTHER_MK;
    bus.key_valid_in = 1'b1;
    tick();
    bus.key_valid_in = 1'b0;
    wait_ready(cycles);
    checks++;
    if (cycles != 21) $display("FAIL ign_latency got %0d cycles want 21", cycles);
    else passed++;
    bus.decrypt_in = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.round_index_in = 5'(i);
      exp_q.push_back(gold[31 - i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL ign_dec_idx%0d got %h want %h", i, bus.round_key_out, exp);
      else passed++;
    end
    bus.decrypt_in = 1'b0;
  endtask

  task automatic test_reset_mid_expand;
    int cycles;
    logic [31:0] exp;
    load_key(OTHER_MK);
    for (int i = 0; i < 15; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.key_ready_out !== 1'b1) $display("FAIL rstmid_key_ready got %b want 1", bus.key_ready_out);
    else passed++;
    checks++;
    if (bus.keys_ready_out !== 1'b0) $display("FAIL rstmid_keys_ready got %b want 0", bus.keys_ready_out);
    else passed++;
    checks++;
    if (bus.round_key_out !== 32'h0) $display("FAIL rstmid_round_key got %h want 0", bus.round_key_out);
    else passed++;
    load_key(STD_MK);
    wait_ready(cycles);
    checks++;
    if (cycles != 32) $display("FAIL rstmid_latency got %0d cycles want 32", cycles);
    else passed++;
    bus.round_index_in = 5'd0;
    exp_q.push_back(32'hf12186f9);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (bus.round_key_out !== exp) $display("FAIL rstmid_rk0 got %h want %h", bus.round_key_out, exp);
    else passed++;
  endtask

  task automatic test_rekey_zero;
    int cycles;
    logic [31:0] exp;
    model_expand(STD_MK);
    bus.decrypt_in     = 1'b0;
    bus.round_index_in = 5'd5;
    exp_q.push_back(gold[5]);
    load_key(128'h0);
    exp = exp_q.pop_front();
    checks++;
    if (bus.round_key_out !== exp) $display("FAIL rekey_old_rk5 got %h want %h", bus.round_key_out, exp);
    else passed++;
    cycles = 0;
    while (bus.keys_ready_out !== 1'b1 && cycles < 40) begin
      bus.round_index_in = 5'(cycles);
      exp_q.push_back(32'h0);
      tick();
      cycles++;
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL rekey_zero_out cyc%0d got %h want %h", cycles, bus.round_key_out, exp);
      else passed++;
    end
    checks++;
    if (cycles != 32) $display("FAIL rekey_latency got %0d cycles want 32", cycles);
    else passed++;
    model_expand(128'h0);
    for (int i = 0; i < 32; i++) begin
      bus.round_index_in = 5'(i);
      exp_q.push_back(gold[i]);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.round_key_out !== exp) $display("FAIL zero_rk%0d got %h want %h", i, bus.round_key_out, exp);
      else passed++;
    end
  endtask

  initial begin
    reset              = 1'b1;
    bus.key_in         = '0;
    bus.key_valid_in   = 1'b0;
    bus.round_index_in = 5'd0;
    bus.decrypt_in     = 1'b0;
    test_reset();
    test_standard_vector();
    test_decrypt_order();
    test_back_to_back();
    test_ignore_during_expand();
    test_reset_mid_expand();
    test_rekey_zero();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sm4_key_schedule.md
# sm4_key_schedule

Generates the 32 SM4 round keys from a 128-bit master key and serves them, one per request, to the encrypt/decrypt round datapath. Keys are produced in forward order (rk0..rk31). Encryption reads them in forward order and decryption in reverse. The block sits between key loading and the round pipeline, and is the producer side of the round-key interface the round function consumes.

## Interface
Parameters: none. All SM4 constants come from the shared include file.

Ports:
- clk  in  1  single clock; all logic is posedge clk
- reset  in  1  synchronous, active-high
- key_in  in  128  master key MK0..MK3, with MK0 in [127:96]
- key_valid_in  in  1  request expansion of key_in
- key_ready_out  out  1  high when a new key is accepted (IDLE or READY)
- keys_ready_out  out  1  high when all 32 round keys are valid
- round_index_in  in  5  logical round number, 0..31
- decrypt_in  in  1  0 = forward order (rk[idx]); 1 = reverse order (rk[31-idx])
- round_key_out  out  32  registered round key for the previous cycle's request

## Operation
- State machine with three states:
  - IDLE: after reset.
  - EXPAND: 32 cycles.
  - READY: keys held.
- Transitions:
  - IDLE → EXPAND when key_valid_in.
  - EXPAND → READY when cnt == 31.
  - READY → EXPAND when key_valid_in.
  - No other transitions.
- Accept: key_valid_in && key_ready_out. key_ready_out = (state != EXPAND).
- key_valid_in during EXPAND is ignored. It is not queued.
- On accept:
  - K register = {MK0^FK0, MK1^FK1, MK2^FK2, MK3^FK3}.
  - cnt is set to 0.
  - keys_ready_out is cleared on the next edge.
- EXPAND cycle i (cnt = i):
  - rk_i = K0 ^ T'(K1^K2^K3^CK_i).
  - T'(B) = L'(τ(B)), where τ is four parallel S-boxes and L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - store[i] ← rk_i.
  - K ← {K1, K2, K3, rk_i}.
  - cnt ← cnt+1, wrapping 31 → 0 on exit.
- Key store: 32×32 registers. It is written only in EXPAND and holds its contents in READY and IDLE.
- Read path:
  - addr = decrypt_in ? (31 - round_index_in) : round_index_in. The 5-bit subtraction needs no range check.
  - round_key_out ← keys_ready_out ? store[addr] : 32'h0.
- Reset mid-EXPAND: state goes to IDLE. keys_ready_out, cnt, round_key_out and the K register are all cleared. Partial store contents are don't-care.
- Re-key while READY:
  - keys_ready_out falls the cycle after accept.
  - round_key_out returns 0 until the new expansion completes.

## Timing
- Reset values:
  - state IDLE, cnt 0, K 0.
  - keys_ready_out 0, round_key_out 32'h0.
  - key_ready_out 1, since it is combinational from state.
- Accept on edge t:
  - rk0 is written on edge t+1 and rk31 on edge t+32.
  - keys_ready_out is high from edge t+32, i.e. visible in cycle t+32 onward.
  - Total: 32 cycles key-to-ready. A new key is accepted again in cycle t+32.
- Read latency is 1 cycle: round_index_in and decrypt_in sampled at edge n give round_key_out after edge n.
- Full throughput: a new index every cycle, with no stalls.
- Simultaneous key_valid_in and a read in READY: the read in that same cycle returns the old key. The next read returns 0.

## Structure
- Shared include file (sm4_defines.vh) holds:
  - FK0..FK3.
  - The 32-entry CK table.
  - The S-box function, which is shared with the round datapath.
- One sub-module: one_round_for_key_expansion.
  - Combinational.
  - Input: the 128-bit K plus CK_i. Output: the shifted K.
  - Mirrors the round function, but uses L' instead of L.
- The top level holds the FSM, cnt, K register, key store and read register.

## Test plan
- Standard vector: MK = 0123456789abcdeffedcba9876543210.
  - Expected: rk0 = f12186f9, rk1 = 41662b61, rk31 = 9124a012.
  - keys_ready_out rises exactly 32 cycles after accept.
- Decrypt order: decrypt_in=1, round_index_in=0 → 9124a012 next cycle. round_index_in=31 → f12186f9.
- Back-to-back reads: sweep index 0..31, one per cycle → 32 consecutive correct keys with no bubbles.
- key_valid_in with a different key during EXPAND cycle 10 → ignored. Final keys still match the standard vector.
- Reset asserted at EXPAND cycle 15 → next cycle: IDLE, keys_ready_out 0, round_key_out 0, key_ready_out 1. A re-key then yields the correct rk0.
- Re-key in READY with MK = all-zero → round_key_out is 0 while expanding. Afterwards all 32 keys match the golden model for the zero key.
